servo_sequencer: RTL and testbench
==================================

// Module: servo_sequencer
// PURPOSE
//   N-channel hobby-servo controller for the arm: one 50 Hz PWM output per joint, per-frame slew limiting,
//   and a waypoint playback FSM reading position tables from ROM (servo*.hex). Live mode tracks an external
//   position bus (accelerometer path) instead. Replaces per-joint PWM instances plus ad-hoc ROM glue at top level.
// PARAMETERS
//   NUM_CH      3           number of servo channels
//   DATA_W      8           position width; 0 = MIN_US, 2^DATA_W-1 = near MAX_US
//   ADDR_W      8           waypoint ROM address width
//   SEQ_LEN     16          waypoints per sequence (1..2^ADDR_W)
//   CLK_HZ      50_000_000  clk frequency
//   PWM_HZ      50          frame rate (period = CLK_HZ/PWM_HZ cycles)
//   MIN_US      1000        pulse width at pos 0
//   MAX_US      2000        full-scale pulse width
//   SLEW        4           max position change per channel per frame (LSBs)
//   HOLD_FRAMES 25          frames held at a reached waypoint
//   LOOP        0           1: restart at address 0 after last waypoint
// PORTS
//   clk       in   1                 system clock
//   rst       in   1                 synchronous, active-high reset
//   en        in   1                 0: all pwm_out low, frame counter held at 0
//   mode      in   1                 0 live, 1 playback
//   start     in   1                 1-cycle pulse; starts playback from address 0 (ignored unless mode=1 and IDLE/DONE)
//   live_pos  in   NUM_CH*DATA_W     live targets, channel i at [i*DATA_W +: DATA_W]
//   rom_addr  out  ADDR_W            shared waypoint address to all channel ROMs
//   rom_data  in   NUM_CH*DATA_W     ROM outputs, same packing; sampled one cycle after rom_addr changes
//   pwm_out   out  NUM_CH            servo pulses
//   busy      out  1                 1 while FSM not IDLE/DONE
//   done      out  1                 1-cycle pulse on completing last waypoint
// BEHAVIOUR
//   Reset: pwm_out=0, rom_addr=0, busy=0, done=0, FSM=IDLE, cur_pos=target=2^(DATA_W-1) (centre), frame_cnt=0.
//   Frame: frame_cnt 0..PERIOD-1, PERIOD=CLK_HZ/PWM_HZ; frame_tick 1 cycle when frame_cnt==PERIOD-1.
//   Width: MIN_CYC=CLK_HZ/1e6*MIN_US; SCALE=((MAX_US-MIN_US)*CLK_HZ/1e6)>>DATA_W (integer, elaborated);
//     width_i = MIN_CYC + cur_pos_i*SCALE, latched at frame start only (no mid-frame glitch).
//     pwm_out[i] = en && (frame_cnt < width_i). Defaults: pos 0 -> 50000 cycles, pos 255 -> 99725.
//   Slew on frame_tick, per channel: |target-cur|<=SLEW -> cur=target; else cur moves SLEW toward target.
//     Unsigned compare; no wrap; cur never overshoots. settled = all cur==target.
//   Live (mode=0): target=live_pos every cycle; FSM forced to IDLE; busy=0.
//   Playback FSM (mode=1):
//     IDLE  --start--> FETCH (rom_addr=0)
//     FETCH 1 cycle    -> LOAD
//     LOAD  target<=rom_data -> SLEW
//     SLEW  settled && frame_tick -> HOLD (hold_cnt=0)
//     HOLD  count frame_ticks; at HOLD_FRAMES -> NEXT
//     NEXT  rom_addr==SEQ_LEN-1: done=1, LOOP ? FETCH at 0 : DONE; else rom_addr+1 -> FETCH
//     DONE  holds last position; start -> FETCH at 0
//   Mode 1->0 mid-sequence: FSM to IDLE next cycle, rom_addr kept, slew continues toward live_pos.
//   start while busy: ignored. en=0: slew, FSM and counters frozen; targets still update in live mode.
//   rst mid-frame/mid-sequence: full reset values next cycle; pwm_out low immediately after rst edge.
// STRUCTURE
//   Package servo_pkg: FSM state enum (IDLE,FETCH,LOAD,SLEW,HOLD,NEXT,DONE), derived constants PERIOD,
//     MIN_CYC, SCALE, and a function clog2 for counter widths.
//   Sub-module servo_channel (xNUM_CH via generate): slew register, width latch, comparator; shares
//     frame_cnt/frame_tick from top. Top holds frame counter, FSM, address counter.
// TESTING (bench overrides CLK_HZ=1_000_000, PWM_HZ=1000 -> PERIOD=1000, MIN_CYC=1000? no: use MIN_US=100,MAX_US=356 -> MIN_CYC=100, SCALE=1)
//   1 rst held 3 cycles -> pwm_out=0, busy=0, rom_addr=0; after release ch0 high 228 cycles (100+128) of 1000.
//   2 mode=0, live ch0 0->40 from centre 128, SLEW=4 -> width steps 4 per frame, reaches 140 after 22 frames, never below.
//   3 mode=1, SEQ_LEN=3, ROM {10,200,50}, HOLD_FRAMES=2, start -> rom_addr 0,1,2; done pulse once; DONE; busy falls same cycle.
//   4 LOOP=1 same ROM -> rom_addr wraps 2->0, no DONE state, done pulses each pass.
//   5 en=0 mid-frame -> all pwm_out low next cycle, cur_pos unchanged; en=1 -> frame restarts at 0 with old widths.
//   6 rst asserted during HOLD -> IDLE, centre positions, rom_addr=0; start during SLEW ignored (addr unchanged).

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: sequencer state encoding and elaboration-time timing helpers
// shared by the servo sequencer top and its per-joint channels.
package servo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SLEW,
        ST_HOLD,
        ST_NEXT,
        ST_DONE
    } seq_state_t;

    localparam longint US_PER_S = 64'd1_000_000;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        longint v;
        w = 1;
        v = 2;
        while (v < longint'(value)) begin
            w = w + 1;
            v = v * 2;
        end
        return w;
    endfunction

    function automatic int calc_period(input int clk_hz, input int pwm_hz);
        return int'(longint'(clk_hz) / longint'(pwm_hz));
    endfunction

    function automatic int calc_min_cyc(input int clk_hz, input int min_us);
        return int'((longint'(clk_hz) / US_PER_S) * longint'(min_us));
    endfunction

    // Cycles per position LSB; 64-bit intermediate because the
    // span-times-clock product exceeds 32 bits at 50 MHz.
    function automatic int calc_scale(
        input int clk_hz,
        input int min_us,
        input int max_us,
        input int data_w
    );
        longint span;
        span = (longint'(max_us - min_us) * longint'(clk_hz)) / US_PER_S;
        return int'(span >> data_w);
    endfunction

    localparam int PERIOD  = calc_period(50_000_000, 50);
    localparam int MIN_CYC = calc_min_cyc(50_000_000, 1000);
    localparam int SCALE   = calc_scale(50_000_000, 1000, 2000, 8);

endpackage

// File: rtl/servo_channel.sv
// servo_channel: one joint - target register, per-frame slew limiter,
// frame-start width latch and pulse comparator.
// Ports: i_clk, i_rst (sync, active high), i_en, i_frame_cnt/i_frame_tick
//   (shared frame timebase), i_tgt_load/i_tgt (target update),
//   o_pwm (registered servo pulse), o_settled (position == target).
module servo_channel
    import servo_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 20,
    parameter int MIN_CYC = 50000,
    parameter int SCALE   = 195,
    parameter int SLEW    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [CNT_W-1:0]  i_frame_cnt,
    input  logic              i_frame_tick,
    input  logic              i_tgt_load,
    input  logic [DATA_W-1:0] i_tgt,
    output logic              o_pwm,
    output logic              o_settled
);

    localparam logic [DATA_W-1:0] CENTRE  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] SLEW_V  = DATA_W'(SLEW);
    localparam logic [CNT_W-1:0]  MIN_V   = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0]  SCALE_V = CNT_W'(SCALE);
    localparam logic [CNT_W-1:0]  RST_WID = MIN_V + CNT_W'(CENTRE) * SCALE_V;

    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_tgt;
    logic [CNT_W-1:0]  r_width;
    logic              r_pwm;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_cur_next;
    logic [CNT_W-1:0]  w_width_next;

    // Step toward target by at most SLEW; the difference is taken in the
    // direction of travel so the step can never wrap or overshoot.
    always_comb begin
        w_diff     = '0;
        w_cur_next = r_cur;
        if (r_tgt > r_cur) begin
            w_diff     = r_tgt - r_cur;
            w_cur_next = (w_diff <= SLEW_V) ? r_tgt : r_cur + SLEW_V;
        end else if (r_cur > r_tgt) begin
            w_diff     = r_cur - r_tgt;
            w_cur_next = (w_diff <= SLEW_V) ? r_tgt : r_cur - SLEW_V;
        end
    end

    assign w_width_next = MIN_V + CNT_W'(w_cur_next) * SCALE_V;

    // Width only changes on the last cycle of a frame, so a pulse in
    // flight is never shortened or stretched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur   <= CENTRE;
            r_tgt   <= CENTRE;
            r_width <= RST_WID;
            r_pwm   <= 1'b0;
        end else begin
            if (i_tgt_load) begin
                r_tgt <= i_tgt;
            end
            if (i_frame_tick) begin
                r_cur   <= w_cur_next;
                r_width <= w_width_next;
            end
            r_pwm <= i_en && (i_frame_cnt < r_width);
        end
    end

    assign o_pwm     = r_pwm;
    assign o_settled = (r_cur == r_tgt);

endmodule

// File: rtl/servo_sequencer.sv
// servo_sequencer: N-joint 50 Hz servo controller with slew limiting,
// live position tracking and ROM waypoint playback.
// Ports: i_clk, i_rst (sync, active high), i_en, i_mode (0 live, 1 play),
//   i_start, i_live_pos, o_rom_addr/i_rom_data (sync ROM, 1-cycle latency),
//   o_pwm_out, o_busy, o_done (pulse at end of last waypoint).
module servo_sequencer
    import servo_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int SEQ_LEN     = 16,
    parameter int CLK_HZ      = 50_000_000,
    parameter int PWM_HZ      = 50,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000,
    parameter int SLEW        = 4,
    parameter int HOLD_FRAMES = 25,
    parameter int LOOP        = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_mode,
    input  logic                     i_start,
    input  logic [NUM_CH*DATA_W-1:0] i_live_pos,
    output logic [ADDR_W-1:0]        o_rom_addr,
    input  logic [NUM_CH*DATA_W-1:0] i_rom_data,
    output logic [NUM_CH-1:0]        o_pwm_out,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int LP_PERIOD  = calc_period(CLK_HZ, PWM_HZ);
    localparam int LP_MIN_CYC = calc_min_cyc(CLK_HZ, MIN_US);
    localparam int LP_SCALE   = calc_scale(CLK_HZ, MIN_US, MAX_US, DATA_W);
    localparam int CNT_W      = clog2(LP_PERIOD);
    localparam int HOLD_W     = clog2(HOLD_FRAMES);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LP_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SEQ_LEN - 1);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic [CNT_W-1:0]        r_frame_cnt;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W-1:0]       w_addr_nxt;
    logic [HOLD_W-1:0]       r_hold;
    logic [HOLD_W-1:0]       w_hold_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_pb_load;
    logic                    w_frame_tick;
    logic                    w_tgt_load;
    logic                    w_all_settled;
    logic [NUM_CH-1:0]       w_settled;
    logic [NUM_CH-1:0]       w_pwm;
    logic [NUM_CH*DATA_W-1:0] w_tgt_sel;

    // Frame timebase; parked at 0 while disabled so re-enable starts a
    // fresh frame.
    assign w_frame_tick = i_en && (r_frame_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_frame_cnt <= '0;
        end else if (w_frame_tick) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
    end

    // Live mode rewrites targets every cycle, even when disabled.
    assign w_tgt_sel  = i_mode ? i_rom_data : i_live_pos;
    assign w_tgt_load = !i_mode || w_pb_load;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_channel #(
            .DATA_W  (DATA_W),
            .CNT_W   (CNT_W),
            .MIN_CYC (LP_MIN_CYC),
            .SCALE   (LP_SCALE),
            .SLEW    (SLEW)
        ) u_ch (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_en         (i_en),
            .i_frame_cnt  (r_frame_cnt),
            .i_frame_tick (w_frame_tick),
            .i_tgt_load   (w_tgt_load),
            .i_tgt        (w_tgt_sel[g*DATA_W +: DATA_W]),
            .o_pwm        (w_pwm[g]),
            .o_settled    (w_settled[g])
        );
    end

    assign w_all_settled = &w_settled;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_hold  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_hold  <= w_hold_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Playback walks FETCH (ROM latency) -> LOAD -> SLEW -> HOLD -> NEXT.
    // Leaving playback mode drops to IDLE but keeps the address.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_hold_nxt  = r_hold;
        w_done_nxt  = 1'b0;
        w_pb_load   = 1'b0;
        if (!i_mode) begin
            w_state_nxt = ST_IDLE;
        end else if (i_en) begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        w_state_nxt = ST_FETCH;
                        w_addr_nxt  = '0;
                    end
                end
                ST_FETCH: begin
                    w_state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    w_pb_load   = 1'b1;
                    w_state_nxt = ST_SLEW;
                end
                ST_SLEW: begin
                    if (w_all_settled && w_frame_tick) begin
                        w_state_nxt = ST_HOLD;
                        w_hold_nxt  = '0;
                    end
                end
                ST_HOLD: begin
                    if (w_frame_tick) begin
                        if (r_hold == HOLD_LAST) begin
                            w_state_nxt = ST_NEXT;
                        end else begin
                            w_hold_nxt = r_hold + HOLD_W'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_addr == ADDR_LAST) begin
                        w_done_nxt = 1'b1;
                        if (LOOP != 0) begin
                            w_state_nxt = ST_FETCH;
                            w_addr_nxt  = '0;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_state_nxt = ST_FETCH;
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign o_rom_addr = r_addr;
    assign o_pwm_out  = w_pwm;
    assign o_done     = r_done;
    assign o_busy     = i_mode && (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_servo_sequencer.sv
// tb_servo_sequencer: two sequencers (one-shot and looping) on shared
// stimulus, checked every cycle against a frame-level behavioural model.
module tb_servo_sequencer;

    localparam int NCH  = 3;
    localparam int PER  = 1000;
    localparam int MINC = 100;
    localparam int SLW  = 4;
    localparam int HF   = 2;
    localparam int SL   = 3;

    typedef enum int {M_IDLE, M_FETCH, M_LOAD, M_SLEW, M_HOLD, M_NEXT, M_DONE} mph_t;

    logic        clk = 1'b0;
    logic        rst, en, mode, start;
    logic [23:0] live;
    logic [23:0] rom_data_a, rom_data_b;
    logic [7:0]  addr_a, addr_b;
    logic [2:0]  pwm_a, pwm_b;
    logic        busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int rom [SL][NCH];

    int   m_cnt [2];
    int   m_cur [2][NCH];
    int   m_tgt [2][NCH];
    int   m_wid [2][NCH];
    bit   m_pwm [2][NCH];
    mph_t m_ph  [2];
    int   m_addr[2];
    int   m_hold[2];
    bit   m_done[2];

    always #5 clk = ~clk;

    servo_sequencer #(
        .NUM_CH(3), .DATA_W(8), .ADDR_W(8), .SEQ_LEN(SL),
        .CLK_HZ(1_000_000), .PWM_HZ(1000), .MIN_US(100), .MAX_US(356),
        .SLEW(SLW), .HOLD_FRAMES(HF), .LOOP(0)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_start(start),
        .i_live_pos(live), .o_rom_addr(addr_a), .i_rom_data(rom_data_a),
        .o_pwm_out(pwm_a), .o_busy(busy_a), .o_done(done_a)
    );

    servo_sequencer #(
        .NUM_CH(3), .DATA_W(8), .ADDR_W(8), .SEQ_LEN(SL),
        .CLK_HZ(1_000_000), .PWM_HZ(1000), .MIN_US(100), .MAX_US(356),
        .SLEW(SLW), .HOLD_FRAMES(HF), .LOOP(1)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_start(start),
        .i_live_pos(live), .o_rom_addr(addr_b), .i_rom_data(rom_data_b),
        .o_pwm_out(pwm_b), .o_busy(busy_b), .o_done(done_b)
    );

    function automatic logic [23:0] rom_word(input logic [7:0] a);
        logic [23:0] r;
        r = '0;
        if (int'(a) < SL) begin
            for (int ch = 0; ch < NCH; ch++) r[ch*8 +: 8] = 8'(rom[int'(a)][ch]);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        rom_data_a <= rom_word(addr_a);
        rom_data_b <= rom_word(addr_b);
    end

    function automatic int slew_to(input int c, input int t);
        if (t > c) return (t - c <= SLW) ? t : c + SLW;
        return (c - t <= SLW) ? t : c - SLW;
    endfunction

    // Frame-level reference: what each output must be after this edge.
    task automatic model_step(input int k);
        bit tick, settled, ld;
        if (rst) begin
            m_cnt[k] = 0; m_ph[k] = M_IDLE; m_addr[k] = 0;
            m_hold[k] = 0; m_done[k] = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                m_cur[k][ch] = 128; m_tgt[k][ch] = 128;
                m_wid[k][ch] = MINC + 128; m_pwm[k][ch] = 0;
            end
            return;
        end
        tick = en && (m_cnt[k] == PER - 1);
        settled = 1;
        for (int ch = 0; ch < NCH; ch++) if (m_cur[k][ch] != m_tgt[k][ch]) settled = 0;
        for (int ch = 0; ch < NCH; ch++) m_pwm[k][ch] = en && (m_cnt[k] < m_wid[k][ch]);
        m_done[k] = 0;
        ld = 0;
        if (!mode) m_ph[k] = M_IDLE;
        else if (en) begin
            case (m_ph[k])
                M_IDLE, M_DONE: if (start) begin m_ph[k] = M_FETCH; m_addr[k] = 0; end
                M_FETCH: m_ph[k] = M_LOAD;
                M_LOAD: begin ld = 1; m_ph[k] = M_SLEW; end
                M_SLEW: if (settled && tick) begin m_ph[k] = M_HOLD; m_hold[k] = 0; end
                M_HOLD: if (tick) begin
                    if (m_hold[k] + 1 >= HF) m_ph[k] = M_NEXT;
                    else m_hold[k]++;
                end
                M_NEXT: begin
                    if (m_addr[k] == SL - 1) begin
                        m_done[k] = 1;
                        if (k == 1) begin m_ph[k] = M_FETCH; m_addr[k] = 0; end
                        else m_ph[k] = M_DONE;
                    end else begin
                        m_addr[k]++;
                        m_ph[k] = M_FETCH;
                    end
                end
                default: m_ph[k] = M_IDLE;
            endcase
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (tick) begin
                m_cur[k][ch] = slew_to(m_cur[k][ch], m_tgt[k][ch]);
                m_wid[k][ch] = MINC + m_cur[k][ch];
            end
            if (!mode) m_tgt[k][ch] = int'(live[ch*8 +: 8]);
            else if (ld) m_tgt[k][ch] = rom[m_addr[k]][ch];
        end
        m_cnt[k] = (!en || tick) ? 0 : m_cnt[k] + 1;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        logic [12:0] e, a;
        logic [2:0]  ep;
        logic        eb;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                for (int ch = 0; ch < NCH; ch++) ep[ch] = m_pwm[k][ch];
                eb = mode && !(m_ph[k] == M_IDLE || m_ph[k] == M_DONE);
                e = {ep, 8'(m_addr[k]), eb, m_done[k]};
                a = (k == 0) ? {pwm_a, addr_a, busy_a, done_a}
                             : {pwm_b, addr_b, busy_b, done_b};
                checks++;
                if (a !== e) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL cycle_cmp dut%0d t=%0t pwm/addr/busy/done got=%h required=%h",
                                 k, $time, a, e);
                end
            end
        end
    end

    int q_a[$], q_b[$];
    int last_a = 0, last_b = 0;
    int nd_a = 0, nd_b = 0;
    int bd_a = -1, bd_b = -1;
    bit rec = 1'b0;

    always @(negedge clk) begin
        if (rec) begin
            if (int'(addr_a) != last_a) begin q_a.push_back(int'(addr_a)); last_a = int'(addr_a); end
            if (int'(addr_b) != last_b) begin q_b.push_back(int'(addr_b)); last_b = int'(addr_b); end
            if (done_a) begin nd_a++; bd_a = int'(busy_a); end
            if (done_b) begin nd_b++; bd_b = int'(busy_b); end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic measure_pulse(output int len);
        int guard;
        guard = 0;
        len = 0;
        while (pwm_a[0] === 1'b1 && guard < 3000) begin step(); guard++; end
        while (pwm_a[0] !== 1'b1 && guard < 3000) begin step(); guard++; end
        while (pwm_a[0] === 1'b1 && guard < 3000) begin step(); guard++; len++; end
        if (guard >= 3000) chk("pulse_timeout", guard, 0);
    endtask

    initial begin
        int len, prev, steps, lowest, bad, seen, guard, a_before;
        rst = 1; en = 1; mode = 0; start = 0;
        live = {3{8'd128}};
        for (int a = 0; a < SL; a++)
            for (int ch = 0; ch < NCH; ch++) rom[a][ch] = int'($urandom_range(120, 136));

        // reset held three cycles
        step();
        chk_en = 1;
        step(); step();
        chk("rst_pwm", int'(pwm_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_addr", int'(addr_a), 0);
        rst = 0;
        measure_pulse(len);
        chk("centre_width", len, 228);

        // live tracking, channel 0 heads for 40 from centre
        live[7:0]   = 8'd40;
        live[15:8]  = 8'($urandom_range(116, 140));
        live[23:16] = 8'($urandom_range(116, 140));
        prev = 228; steps = 0; lowest = 228; bad = 0; seen = 0;
        for (int i = 0; i < 30 && seen < 2; i++) begin
            measure_pulse(len);
            if (len == prev - 4) steps++;
            else if (!(len == 140 && prev == 140)) bad++;
            if (len < lowest) lowest = len;
            if (len == 140) seen++;
            prev = len;
        end
        chk("slew_final", prev, 140);
        chk("slew_steps", steps, 22);
        chk("slew_floor", lowest, 140);
        chk("slew_irregular", bad, 0);

        // playback, one-shot and looping side by side
        mode = 1;
        step(); step(); step();
        q_a.push_back(0); q_b.push_back(0);
        rec = 1;
        start = 1; step(); start = 0;

        guard = 0;
        while (!(addr_a == 8'd1 && m_ph[0] == M_SLEW) && guard < 30000) begin step(); guard++; end
        chk("reach_slew_timeout", int'(guard >= 30000), 0);
        a_before = int'(addr_a);
        start = 1; step(); start = 0;
        step();
        chk("start_ignored_addr", int'(addr_a), a_before);
        chk("start_ignored_busy", int'(busy_a), 1);

        guard = 0;
        while (nd_a < 1 && guard < 40000) begin step(); guard++; end
        chk("done_a_timeout", int'(guard >= 40000), 0);

        // disable mid-pulse, then re-enable
        guard = 0;
        while (pwm_a[0] !== 1'b1 && guard < 2000) begin step(); guard++; end
        repeat (20) step();
        en = 0;
        step();
        chk("en_off_pwm", int'({pwm_a, pwm_b}), 0);
        repeat (37) step();
        en = 1;
        measure_pulse(len);
        chk("en_resume_width", len, MINC + rom[SL-1][0]);

        guard = 0;
        while (nd_b < 2 && guard < 40000) begin step(); guard++; end
        chk("done_b_timeout", int'(guard >= 40000), 0);
        repeat (3000) step();
        rec = 0;

        chk("seq_a_len", q_a.size(), 3);
        for (int i = 0; i < q_a.size() && i < 3; i++) chk("seq_a_addr", q_a[i], i);
        chk("done_a_count", nd_a, 1);
        chk("done_a_busy", bd_a, 0);
        chk("a_done_busy", int'(busy_a), 0);
        chk("a_done_addr", int'(addr_a), SL - 1);
        chk("seq_b_min_len", int'(q_b.size() >= 6), 1);
        for (int i = 0; i < q_b.size() && i < 6; i++) chk("seq_b_addr", q_b[i], i % 3);
        chk("done_b_busy", bd_b, 1);

        // leave playback mid-sequence
        mode = 0;
        step(); step();
        chk("live_busy_b", int'(busy_b), 0);

        // reset during hold
        mode = 1;
        start = 1; step(); start = 0;
        guard = 0;
        while (m_ph[0] != M_HOLD && guard < 20000) begin step(); guard++; end
        chk("reach_hold_timeout", int'(guard >= 20000), 0);
        rst = 1;
        step();
        chk("rst_hold_pwm", int'({pwm_a, pwm_b}), 0);
        chk("rst_hold_busy", int'({busy_a, busy_b}), 0);
        chk("rst_hold_addr", int'(addr_a), 0);
        rst = 0;
        measure_pulse(len);
        chk("rst_hold_centre", len, 228);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
